// File: rtl/canvas_write_ctrl.sv
// canvas_write_ctrl: buffers draw commands and expands them into per-pixel
// frame-store writes, issued only in cycles the display side grants.
//
// Ports:
//   clk, reset                    clock, async active-high reset
//   cmd_valid/cmd_ready           command handshake from the SPI decoder
//   cmd_op/cmd_x/cmd_y/cmd_color  command fields (op: 0 pixel, 1 brush, 2 clear)
//   wr_allow                      frame-store write port free this cycle
//   we/wx/wy/wcolor               frame-store write port
//   busy                          FIFO non-empty or a command executing
module canvas_write_ctrl #(
    parameter int WIDTH      = 160,
    parameter int HEIGHT     = 120,
    parameter int BRUSH      = 3,
    parameter int FIFO_DEPTH = 4
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       cmd_valid,
    output logic       cmd_ready,
    input  logic [1:0] cmd_op,
    input  logic [7:0] cmd_x,
    input  logic [7:0] cmd_y,
    input  logic [2:0] cmd_color,
    input  logic       wr_allow,
    output logic       we,
    output logic [7:0] wx,
    output logic [7:0] wy,
    output logic [2:0] wcolor,
    output logic       busy
);

    localparam int AW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam logic [7:0] BLAST = 8'(BRUSH - 1);
    localparam logic [8:0] XLIM  = 9'(WIDTH);
    localparam logic [8:0] YLIM  = 9'(HEIGHT);
    localparam logic [8:0] XLAST = 9'(WIDTH - 1);
    localparam logic [8:0] YLAST = 9'(HEIGHT - 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_PIXEL,
        S_BRUSH,
        S_CLEAR
    } state_t;

    state_t r_state;
    state_t w_next;

    // FIFO entry layout: {op[1:0], x[7:0], y[7:0], color[2:0]}
    logic [20:0] r_mem [FIFO_DEPTH];
    logic [AW:0] r_wp;
    logic [AW:0] r_rp;

    logic        w_empty;
    logic        w_full;
    logic        w_push;
    logic        w_pop;
    logic [20:0] w_head;
    logic [1:0]  w_hop;

    // Working registers: r_tx/r_ty always hold the current target pixel,
    // so the write address is driven straight from flops.
    logic [8:0] r_tx;
    logic [8:0] r_ty;
    logic [8:0] r_bx;
    logic [7:0] r_i;
    logic [7:0] r_j;
    logic [2:0] r_color;

    logic w_inr;
    logic w_adv;
    logic w_blast;
    logic w_clast;

    assign w_empty = (r_wp == r_rp);
    assign w_full  = (r_wp[AW] != r_rp[AW]) &&
                     (r_wp[AW-1:0] == r_rp[AW-1:0]);
    assign w_push  = cmd_valid && !w_full;
    assign w_pop   = (r_state == S_IDLE) && !w_empty;
    assign w_head  = r_mem[r_rp[AW-1:0]];
    assign w_hop   = w_head[20:19];

    assign w_inr   = (r_tx < XLIM) && (r_ty < YLIM);
    // Clipped targets advance unconditionally; live ones wait for a grant.
    assign w_adv   = (r_state != S_IDLE) && (!w_inr || wr_allow);
    assign w_blast = (r_i == BLAST) && (r_j == BLAST);
    assign w_clast = (r_tx == XLAST) && (r_ty == YLAST);

    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem[r_wp[AW-1:0]] <= {cmd_op, cmd_x, cmd_y, cmd_color};
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_wp <= '0;
            r_rp <= '0;
        end else begin
            if (w_push) r_wp <= r_wp + 1'b1;
            if (w_pop)  r_rp <= r_rp + 1'b1;
        end
    end

    // FSM: state register
    always_ff @(posedge clk or posedge reset) begin
        if (reset) r_state <= S_IDLE;
        else       r_state <= w_next;
    end

    // FSM: next state
    always_comb begin
        w_next = r_state;
        unique case (r_state)
            S_IDLE: begin
                if (w_pop) begin
                    unique case (w_hop)
                        2'b00:   w_next = S_PIXEL;
                        2'b01:   w_next = S_BRUSH;
                        2'b10:   w_next = S_CLEAR;
                        default: w_next = S_IDLE;
                    endcase
                end
            end
            S_PIXEL: if (w_adv) w_next = S_IDLE;
            S_BRUSH: if (w_adv && w_blast) w_next = S_IDLE;
            S_CLEAR: if (w_adv && w_clast) w_next = S_IDLE;
            default: w_next = S_IDLE;
        endcase
    end

    // FSM: outputs
    always_comb begin
        we        = (r_state != S_IDLE) && w_inr && wr_allow;
        busy      = (r_state != S_IDLE) || !w_empty;
        cmd_ready = !w_full;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_tx    <= '0;
            r_ty    <= '0;
            r_bx    <= '0;
            r_i     <= '0;
            r_j     <= '0;
            r_color <= '0;
        end else if (w_pop) begin
            r_bx    <= {1'b0, w_head[18:11]};
            r_i     <= '0;
            r_j     <= '0;
            r_color <= w_head[2:0];
            if (w_hop == 2'b10) begin
                r_tx <= '0;
                r_ty <= '0;
            end else begin
                r_tx <= {1'b0, w_head[18:11]};
                r_ty <= {1'b0, w_head[10:3]};
            end
        end else if (w_adv) begin
            if (r_state == S_BRUSH) begin
                if (r_i == BLAST) begin
                    r_i  <= '0;
                    r_j  <= r_j + 8'd1;
                    r_tx <= r_bx;
                    r_ty <= r_ty + 9'd1;
                end else begin
                    r_i  <= r_i + 8'd1;
                    r_tx <= r_tx + 9'd1;
                end
            end else if (r_state == S_CLEAR) begin
                if (r_tx == XLAST) begin
                    r_tx <= '0;
                    r_ty <= r_ty + 9'd1;
                end else begin
                    r_tx <= r_tx + 9'd1;
                end
            end
        end
    end

    assign wx     = r_tx[7:0];
    assign wy     = r_ty[7:0];
    assign wcolor = r_color;

endmodule

// File: tb/tb_canvas_write_ctrl.sv
// Testbench for canvas_write_ctrl: scoreboard of expected pixel writes
// built from the command semantics, checked by an independent monitor.
module tb_canvas_write_ctrl;

    localparam int W = 160;
    localparam int H = 120;
    localparam int B = 3;

    logic       clk = 1'b0;
    logic       rst;
    logic       cmd_valid;
    logic       cmd_ready;
    logic [1:0] cmd_op;
    logic [7:0] cmd_x;
    logic [7:0] cmd_y;
    logic [2:0] cmd_color;
    logic       wr_allow;
    logic       we;
    logic [7:0] wx;
    logic [7:0] wy;
    logic [2:0] wcolor;
    logic       busy;

    canvas_write_ctrl #(
        .WIDTH(W), .HEIGHT(H), .BRUSH(B), .FIFO_DEPTH(4)
    ) dut (
        .clk(clk), .reset(rst),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
        .cmd_op(cmd_op), .cmd_x(cmd_x), .cmd_y(cmd_y),
        .cmd_color(cmd_color), .wr_allow(wr_allow),
        .we(we), .wx(wx), .wy(wy), .wcolor(wcolor), .busy(busy)
    );

    always #5 clk = ~clk;

    typedef struct {
        int x;
        int y;
        int c;
    } wr_t;

    wr_t exp_q[$];
    wr_t e;
    int  checks    = 0;
    int  failures  = 0;
    int  cyc       = 0;
    int  wcount    = 0;
    int  last_wcyc = 0;
    int  amode     = 1;  // 0 hold low, 1 hold high, 2 toggle, 3 random

    always @(posedge clk) cyc <= cyc + 1;

    initial begin
        wr_allow = 1'b1;
        forever begin
            @(posedge clk);
            #1;
            case (amode)
                0:       wr_allow = 1'b0;
                1:       wr_allow = 1'b1;
                2:       wr_allow = ~wr_allow;
                default: wr_allow = 1'($urandom_range(0, 1));
            endcase
        end
    end

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // Monitor: every write must be granted and match the scoreboard head.
    always @(negedge clk) begin
        if (!rst && we) begin
            wcount++;
            last_wcyc = cyc;
            checks++;
            if (!wr_allow) begin
                failures++;
                $display("FAIL write_no_allow: we=1 wr_allow=0 at (%0d,%0d)",
                         wx, wy);
            end
            checks++;
            if (exp_q.size() == 0) begin
                failures++;
                $display("FAIL unexpected_write: got (%0d,%0d,c%0d) expected none",
                         wx, wy, wcolor);
            end else begin
                e = exp_q.pop_front();
                if (int'(wx) != e.x || int'(wy) != e.y || int'(wcolor) != e.c) begin
                    failures++;
                    $display("FAIL write_data: got (%0d,%0d,c%0d) expected (%0d,%0d,c%0d)",
                             wx, wy, wcolor, e.x, e.y, e.c);
                end
            end
        end
    end

    task automatic model_push(input int op, input int x, input int y, input int c);
        wr_t t;
        t.c = c;
        case (op)
            0: if (x < W && y < H) begin
                t.x = x; t.y = y; exp_q.push_back(t);
            end
            1: for (int j = 0; j < B; j++)
                for (int i = 0; i < B; i++)
                    if (x + i < W && y + j < H) begin
                        t.x = x + i; t.y = y + j; exp_q.push_back(t);
                    end
            2: for (int cy = 0; cy < H; cy++)
                for (int cx = 0; cx < W; cx++) begin
                    t.x = cx; t.y = cy; exp_q.push_back(t);
                end
            default: ;
        endcase
    endtask

    // Called at a negedge; returns at the negedge after the accepting edge.
    task automatic send(input int op, input int x, input int y, input int c,
                        output int acc, output int waits);
        int n = 0;
        cmd_op    = 2'(op);
        cmd_x     = 8'(x);
        cmd_y     = 8'(y);
        cmd_color = 3'(c);
        cmd_valid = 1'b1;
        while (!cmd_ready && n < 2000) begin
            @(negedge clk);
            n++;
        end
        waits = n;
        acc   = cyc + 1;
        if (!cmd_ready) begin
            checks++;
            failures++;
            $display("FAIL send_timeout: cmd_ready=0 after %0d cycles", n);
        end else begin
            model_push(op, x, y, c);
            @(negedge clk);
        end
        cmd_valid = 1'b0;
    endtask

    task automatic wait_idle(input int budget);
        int n = 0;
        while (busy && n < budget) begin
            @(negedge clk);
            n++;
        end
        chk("idle_timeout", int'(busy), 0);
    endtask

    int acc, wt, w0, bc, n;

    initial begin
        rst       = 1'b0;
        cmd_valid = 1'b0;
        cmd_op    = '0;
        cmd_x     = '0;
        cmd_y     = '0;
        cmd_color = '0;
        #2 rst = 1'b1;
        #1;
        chk("rst_we", int'(we), 0);
        chk("rst_wx", int'(wx), 0);
        chk("rst_wy", int'(wy), 0);
        chk("rst_wcolor", int'(wcolor), 0);
        chk("rst_busy", int'(busy), 0);
        chk("rst_ready", int'(cmd_ready), 1);
        repeat (2) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);

        // single pixel, latency
        amode = 1;
        w0 = wcount;
        send(0, 10, 20, 5, acc, wt);
        wait_idle(50);
        chk("px_writes", wcount - w0, 1);
        chk("px_latency", last_wcyc - acc, 1);
        chk("px_busy", int'(busy), 0);

        // clipped brush in the bottom-right corner
        w0 = wcount;
        send(1, 158, 119, 3, acc, wt);
        bc = 0;
        n  = 0;
        while (busy && n < 100) begin
            bc++;
            @(negedge clk);
            n++;
        end
        chk("brush_busy_cycles", bc, 10);
        chk("brush_writes", wcount - w0, 2);

        // full clear with alternating grants
        amode = 2;
        w0 = wcount;
        send(2, 0, 0, 1, acc, wt);
        wait_idle(50000);
        chk("clear_writes", wcount - w0, W * H);
        amode = 1;
        @(negedge clk);

        // fill the FIFO while writes are blocked
        amode = 0;
        w0 = wcount;
        for (int k = 0; k < 5; k++) begin
            send(0, 10 * k, k, k, acc, wt);
            chk($sformatf("fill_wait_%0d", k), wt, 0);
        end
        chk("full_ready", int'(cmd_ready), 0);
        repeat (3) @(negedge clk);
        chk("full_ready_hold", int'(cmd_ready), 0);
        chk("full_no_writes", wcount - w0, 0);
        chk("full_busy", int'(busy), 1);
        amode = 1;
        send(0, 50, 5, 6, acc, wt);
        wait_idle(200);
        chk("fill_writes", wcount - w0, 6);

        // reset in the middle of a clear
        send(2, 0, 0, 2, acc, wt);
        repeat (100) @(negedge clk);
        rst = 1'b1;
        #1;
        chk("midrst_we", int'(we), 0);
        chk("midrst_busy", int'(busy), 0);
        chk("midrst_ready", int'(cmd_ready), 1);
        exp_q.delete();
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        w0 = wcount;
        send(0, 1, 2, 7, acc, wt);
        wait_idle(50);
        chk("post_rst_writes", wcount - w0, 1);

        // reserved op followed by a pixel
        w0 = wcount;
        send(3, 5, 5, 4, acc, wt);
        send(0, 6, 7, 2, acc, wt);
        wait_idle(50);
        chk("reserved_writes", wcount - w0, 1);

        // random pixels / brushes / reserved with random grants
        amode = 3;
        for (int k = 0; k < 40; k++) begin
            int op;
            op = int'($urandom_range(0, 3));
            if (op == 2) op = 1;
            send(op, int'($urandom_range(0, 165)), int'($urandom_range(0, 125)),
                 int'($urandom_range(0, 7)), acc, wt);
            repeat ($urandom_range(0, 2)) @(negedge clk);
        end
        wait_idle(5000);
        amode = 1;
        repeat (5) @(negedge clk);
        chk("sb_empty", exp_q.size(), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
